// File: rtl/temp_ctrl_pkg.sv
// Types and default constants shared by the setpoint, comparator and display stages.
package temp_ctrl_pkg;

  localparam int SP_W       = 8;
  localparam int SP_MIN     = 18;
  localparam int SP_MAX     = 30;
  localparam int SP_DEFAULT = 24;

  typedef enum logic [2:0] {
    IDLE,
    HOLD_UP,
    HOLD_DN,
    RPT_UP,
    RPT_DN,
    BOTH
  } sp_state_e;

endpackage

// File: rtl/setpoint_ctrl.sv
// Comfort setpoint from debounced up/down buttons: single step, hold-to-repeat,
// saturating at the rails, and both-button hold to restore the default.
module setpoint_ctrl #(
  parameter int SP_W          = temp_ctrl_pkg::SP_W,
  parameter int SP_MIN        = temp_ctrl_pkg::SP_MIN,
  parameter int SP_MAX        = temp_ctrl_pkg::SP_MAX,
  parameter int SP_DEFAULT    = temp_ctrl_pkg::SP_DEFAULT,
  parameter int STEP          = 1,
  parameter int HOLD_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            btn_up,
  input  logic            btn_down,
  input  logic            lock,
  output logic [SP_W-1:0] setpoint,
  output logic            sp_changed,
  output logic            limit_hit
);
  import temp_ctrl_pkg::*;

  localparam int CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] RPT_LAST   = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [SP_W:0]    STEP_X     = (SP_W+1)'(STEP);
  localparam logic [SP_W:0]    MAX_X      = (SP_W+1)'(SP_MAX);
  localparam logic [SP_W:0]    MIN_STEP_X = (SP_W+1)'(SP_MIN + STEP);
  localparam logic [SP_W-1:0]  DEF_X      = SP_W'(SP_DEFAULT);

  if (SP_MIN > SP_DEFAULT || SP_DEFAULT > SP_MAX || STEP < 1 ||
      HOLD_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_param_check
    $error("setpoint_ctrl: invalid parameter set");
  end

  sp_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [SP_W-1:0]  setpoint_q, setpoint_d;
  logic             sp_changed_q, sp_changed_d;
  logic             limit_hit_q, limit_hit_d;
  logic             up_q, down_q;

  logic             rise_up, rise_down;
  logic             step_up, step_dn, load_def;
  logic [SP_W:0]    sp_ext, sp_plus, sp_minus;

  assign rise_up   = btn_up & ~up_q;
  assign rise_down = btn_down & ~down_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    done_d   = done_q;
    step_up  = 1'b0;
    step_dn  = 1'b0;
    load_def = 1'b0;

    if (lock) begin
      state_d = IDLE;
      cnt_d   = '0;
      done_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (rise_up && !btn_down) begin
            step_up = 1'b1;
            state_d = HOLD_UP;
          end else if (rise_down && !btn_up) begin
            step_dn = 1'b1;
            state_d = HOLD_DN;
          end else if (btn_up && btn_down && (rise_up || rise_down)) begin
            done_d  = 1'b0;
            state_d = BOTH;
          end
        end
        HOLD_UP, RPT_UP: begin
          if (!btn_up) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else if (btn_down) begin
            cnt_d   = '0;
            done_d  = 1'b0;
            state_d = BOTH;
          end else if (cnt_q == ((state_q == HOLD_UP) ? HOLD_LAST : RPT_LAST)) begin
            step_up = 1'b1;
            cnt_d   = '0;
            state_d = RPT_UP;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        HOLD_DN, RPT_DN: begin
          if (!btn_down) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else if (btn_up) begin
            cnt_d   = '0;
            done_d  = 1'b0;
            state_d = BOTH;
          end else if (cnt_q == ((state_q == HOLD_DN) ? HOLD_LAST : RPT_LAST)) begin
            step_dn = 1'b1;
            cnt_d   = '0;
            state_d = RPT_DN;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        BOTH: begin
          // Restore fires once per both-hold; done_q keeps it from re-arming.
          if (!btn_up && !btn_down) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else if (btn_up && btn_down && !done_q) begin
            if (cnt_q == HOLD_LAST) begin
              load_def = 1'b1;
              done_d   = 1'b1;
              cnt_d    = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      endcase
    end
  end

  assign sp_ext   = {1'b0, setpoint_q};
  assign sp_plus  = sp_ext + STEP_X;
  assign sp_minus = sp_ext - STEP_X;

  always_comb begin
    setpoint_d   = setpoint_q;
    sp_changed_d = 1'b0;
    limit_hit_d  = 1'b0;
    if (step_up) begin
      if (sp_plus <= MAX_X) begin
        setpoint_d   = sp_plus[SP_W-1:0];
        sp_changed_d = 1'b1;
      end else begin
        limit_hit_d = 1'b1;
      end
    end else if (step_dn) begin
      if (sp_ext >= MIN_STEP_X) begin
        setpoint_d   = sp_minus[SP_W-1:0];
        sp_changed_d = 1'b1;
      end else begin
        limit_hit_d = 1'b1;
      end
    end else if (load_def) begin
      setpoint_d   = DEF_X;
      sp_changed_d = (setpoint_q != DEF_X);
    end
  end

  // Edge registers load the live levels in reset so a held button gives no edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      done_q       <= 1'b0;
      setpoint_q   <= DEF_X;
      sp_changed_q <= 1'b0;
      limit_hit_q  <= 1'b0;
      up_q         <= btn_up;
      down_q       <= btn_down;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      done_q       <= done_d;
      setpoint_q   <= setpoint_d;
      sp_changed_q <= sp_changed_d;
      limit_hit_q  <= limit_hit_d;
      up_q         <= btn_up;
      down_q       <= btn_down;
    end
  end

  assign setpoint   = setpoint_q;
  assign sp_changed = sp_changed_q;
  assign limit_hit  = limit_hit_q;

endmodule

// File: tb/tb_setpoint_ctrl.sv
// Directed bench for setpoint_ctrl with short hold/repeat times (8 / 4 clocks).
module tb_setpoint_ctrl;

  logic       clk;
  logic       reset;
  logic       btn_up;
  logic       btn_down;
  logic       lock;
  logic [7:0] setpoint;
  logic       sp_changed;
  logic       limit_hit;

  int checks   = 0;
  int failures = 0;

  setpoint_ctrl #(
    .SP_W(8), .SP_MIN(18), .SP_MAX(30), .SP_DEFAULT(24), .STEP(1),
    .HOLD_CYCLES(8), .REPEAT_CYCLES(4)
  ) dut (
    .clk(clk), .reset(reset), .btn_up(btn_up), .btn_down(btn_down), .lock(lock),
    .setpoint(setpoint), .sp_changed(sp_changed), .limit_hit(limit_hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       up;
    logic       dn;
    logic       lk;
    logic [7:0] sp;
    logic       chg;
    logic       lim;
  } vec_t;

  vec_t vecs[22];

  // Inputs change just after a rising edge; outputs are sampled 1 time unit after the next one.
  task automatic applyStimulus(input logic r, input logic u, input logic d, input logic l);
    reset    = r;
    btn_up   = u;
    btn_down = d;
    lock     = l;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] esp,
                             input logic echg, input logic elim);
    checks++;
    if (setpoint !== esp || sp_changed !== echg || limit_hit !== elim) begin
      failures++;
      $display("[TB] FAIL %s: got sp=%0d chg=%b lim=%b, want sp=%0d chg=%b lim=%b",
               name, setpoint, sp_changed, limit_hit, esp, echg, elim);
    end
  endtask

  task automatic pressButton(input string name, input logic u, input logic d,
                             input logic [7:0] esp);
    applyStimulus(1'b0, u, d, 1'b0);
    checkOutput(name, esp, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput(name, esp, 1'b0, 1'b0);
  endtask

  logic [7:0] exp_sp;
  logic       stp;
  logic       lim_exp;

  initial begin
    reset = 1'b1; btn_up = 1'b0; btn_down = 1'b0; lock = 1'b0;

    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd24, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd24, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd25, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd25, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd25, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd25, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'd25, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd25, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'd25, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd25, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'd25, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd25, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd25, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd25, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd26, 1'b1, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd26, 1'b0, 1'b0};
    vecs[16] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'd25, 1'b1, 1'b0};
    vecs[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd25, 1'b0, 1'b0};
    vecs[18] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'd24, 1'b0, 1'b0};
    vecs[19] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd24, 1'b0, 1'b0};
    vecs[20] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd24, 1'b0, 1'b0};
    vecs[21] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd24, 1'b0, 1'b0};

    for (int v = 0; v < 22; v++) begin
      applyStimulus(vecs[v].rst, vecs[v].up, vecs[v].dn, vecs[v].lk);
      checkOutput($sformatf("vec%0d", v), vecs[v].sp, vecs[v].chg, vecs[v].lim);
    end

    // Hold up from 24: steps on cycles 0, 8, 12, 16 of the hold.
    exp_sp = 8'd24;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      stp = (i == 0 || i == 8 || i == 12 || i == 16);
      if (stp) exp_sp = exp_sp + 8'd1;
      checkOutput($sformatf("hold_up_c%0d", i), exp_sp, stp, 1'b0);
    end
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("hold_up_release", 8'd28, 1'b0, 1'b0);
    end

    // Hold up from 29: one real step to 30, then refused repeats.
    pressButton("press_to_29", 1'b1, 1'b0, 8'd29);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      lim_exp = (i == 8 || i == 12 || i == 16);
      checkOutput($sformatf("max_rail_c%0d", i), 8'd30, (i == 0), lim_exp);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("max_rail_release", 8'd30, 1'b0, 1'b0);

    // Mirror at the lower rail.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("reset_before_min", 8'd24, 1'b0, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      pressButton("press_down", 1'b0, 1'b1, 8'(24 - k));
    end
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      lim_exp = (i == 8 || i == 12 || i == 16);
      checkOutput($sformatf("min_rail_c%0d", i), 8'd18, (i == 0), lim_exp);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("min_rail_release", 8'd18, 1'b0, 1'b0);

    // Both-button restore from 27.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("reset_before_both", 8'd24, 1'b0, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      pressButton("press_up", 1'b1, 1'b0, 8'(24 + k));
    end
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
      if (i < 8) checkOutput($sformatf("both_c%0d", i), 8'd27, 1'b0, 1'b0);
      else       checkOutput($sformatf("both_c%0d", i), 8'd24, (i == 8), 1'b0);
    end
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("both_release_down", 8'd24, 1'b0, 1'b0);
    end
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("both_release_up", 8'd24, 1'b0, 1'b0);
    end
    pressButton("press_after_both", 1'b1, 1'b0, 8'd25);

    // Reset while auto-repeating up.
    exp_sp = 8'd25;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      stp = (i == 0 || i == 8);
      if (stp) exp_sp = exp_sp + 8'd1;
      checkOutput($sformatf("pre_reset_c%0d", i), exp_sp, stp, 1'b0);
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("reset_mid_repeat", 8'd24, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput($sformatf("held_after_reset_c%0d", i), 8'd24, 1'b0, 1'b0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("final_release", 8'd24, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
